// File: rtl/if_inst_buffer_pkg.sv
// Shared fetch-side defines for the instruction buffer: default depth, NOOP encoding,
// the stored entry layout and the decode-take decoder.
package if_inst_buffer_pkg;

  localparam int unsigned IFB_DEPTH = 8;
  localparam logic [31:0] NOOP_INST = 32'h47ff041f;

  localparam int unsigned IR_W    = 32;
  localparam int unsigned PC_W    = 64;
  localparam int unsigned ENTRY_W = IR_W + PC_W;

  typedef struct packed {
    logic [IR_W-1:0] ir;
    logic [PC_W-1:0] pc;
  } ifb_entry_t;

  // Instructions decode wants this cycle; "none" overrides "one".
  function automatic logic [1:0] take_count(input logic non_ins_en, input logic one_ins_en);
    if (non_ins_en) return 2'd0;
    else if (one_ins_en) return 2'd1;
    else return 2'd2;
  endfunction

endpackage

// File: rtl/if_inst_buffer_ifb_ram.sv
// Instruction buffer storage: DEPTH entries of {IR, PC}, two write ports and two
// asynchronous read ports. Callers never write the same address on both ports.
module ifb_ram
  import if_inst_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = IFB_DEPTH
) (
  input  logic                     clock,
  input  logic                     we0,
  input  logic [$clog2(DEPTH)-1:0] waddr0,
  input  ifb_entry_t               wdata0,
  input  logic                     we1,
  input  logic [$clog2(DEPTH)-1:0] waddr1,
  input  ifb_entry_t               wdata1,
  input  logic [$clog2(DEPTH)-1:0] raddr0,
  input  logic [$clog2(DEPTH)-1:0] raddr1,
  output ifb_entry_t               rdata0,
  output ifb_entry_t               rdata1
);

  ifb_entry_t mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we0) mem[waddr0] <= wdata0;
    if (we1) mem[waddr1] <= wdata1;
  end

  assign rdata0 = mem[raddr0];
  assign rdata1 = mem[raddr1];

endmodule

// File: rtl/if_inst_buffer.sv
// Fetch-to-decode instruction FIFO: accepts 64-bit fetch lines, presents the two oldest
// instructions to decode. Optional same-cycle bypass when empty: define IFB_BYPASS_EN.
module if_inst_buffer
  import if_inst_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = IFB_DEPTH
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        if_valid_in,
  input  logic [63:0] if_pc_in,
  input  logic [63:0] mem2proc_data,
  input  logic        flush_in,
  input  logic        one_ins_en_in,
  input  logic        non_ins_en_in,
  output logic        if_stall_out,
  output logic [31:0] if_IRA_out,
  output logic [31:0] if_IRB_out,
  output logic [63:0] if_NPCA_out,
  output logic [63:0] if_NPCB_out,
  output logic        if_IRA_valid_out,
  output logic        if_IRB_valid_out
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [CW-1:0] count;

  logic          stall;
  logic          enq;
  logic [1:0]    take;
  logic [1:0]    nwords;
  logic [1:0]    skip;
  logic [1:0]    wn;
  logic [CW-1:0] deq;
  logic          bypass;
  ifb_entry_t    w0;
  ifb_entry_t    w1;
  ifb_entry_t    rd0;
  ifb_entry_t    rd1;
  ifb_entry_t    slot_a;
  ifb_entry_t    slot_b;
  logic          a_valid;
  logic          b_valid;

  // Stall from the registered occupancy only; a same-cycle dequeue earns no credit.
  assign stall        = (CW'(DEPTH) - count) < CW'(2);
  assign if_stall_out = stall;

  assign enq    = if_valid_in && !stall && !flush_in;
  assign take   = take_count(non_ins_en_in, one_ins_en_in);
  assign nwords = if_pc_in[2] ? 2'd1 : 2'd2;
  assign deq    = (CW'(take) > count) ? count : CW'(take);

  // w0 is the first valid word of the line; w1 only exists for an 8-byte aligned fetch.
  always_comb begin
    w0    = '0;
    w1    = '0;
    w0.ir = if_pc_in[2] ? mem2proc_data[63:32] : mem2proc_data[31:0];
    w0.pc = if_pc_in;
    w1.ir = mem2proc_data[63:32];
    w1.pc = if_pc_in + 64'd4;
  end

`ifdef IFB_BYPASS_EN
  // Empty buffer: decode may consume incoming words directly, so fewer are written.
  assign bypass = enq && (count == '0);
  assign skip   = bypass ? ((take < nwords) ? take : nwords) : 2'd0;
`else
  assign bypass = 1'b0;
  assign skip   = 2'd0;
`endif

  assign wn = enq ? (nwords - skip) : 2'd0;

  ifb_ram #(
    .DEPTH (DEPTH)
  ) u_ram (
    .clock  (clock),
    .we0    (wn != 2'd0),
    .waddr0 (tail),
    .wdata0 ((skip != 2'd0) ? w1 : w0),
    .we1    (wn == 2'd2),
    .waddr1 (tail + AW'(1)),
    .wdata1 (w1),
    .raddr0 (head),
    .raddr1 (head + AW'(1)),
    .rdata0 (rd0),
    .rdata1 (rd1)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush_in) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + AW'(deq);
      tail  <= tail + AW'(wn);
      count <= count + CW'(wn) - deq;
    end
  end

  // Decode view: bypass only ever fires with an empty buffer, so it never mixes with storage.
  always_comb begin
    a_valid = (count >= CW'(1)) || bypass;
    b_valid = (count >= CW'(2)) || (bypass && (nwords == 2'd2));
    slot_a  = bypass ? w0 : rd0;
    slot_b  = bypass ? w1 : rd1;
  end

  assign if_IRA_valid_out = a_valid;
  assign if_IRB_valid_out = b_valid;
  assign if_IRA_out       = a_valid ? slot_a.ir : NOOP_INST;
  assign if_IRB_out       = b_valid ? slot_b.ir : NOOP_INST;
  assign if_NPCA_out      = a_valid ? (slot_a.pc + 64'd4) : 64'd0;
  assign if_NPCB_out      = b_valid ? (slot_b.pc + 64'd4) : 64'd0;

endmodule

// File: tb/tb_if_inst_buffer.sv
// Directed self-checking bench for if_inst_buffer (default build, DEPTH=8).
module tb_if_inst_buffer;

  localparam logic [31:0] NOOP = 32'h47ff041f;

  logic        clock;
  logic        reset;
  logic        if_valid_in;
  logic [63:0] if_pc_in;
  logic [63:0] mem2proc_data;
  logic        flush_in;
  logic        one_ins_en_in;
  logic        non_ins_en_in;
  logic        if_stall_out;
  logic [31:0] if_IRA_out;
  logic [31:0] if_IRB_out;
  logic [63:0] if_NPCA_out;
  logic [63:0] if_NPCB_out;
  logic        if_IRA_valid_out;
  logic        if_IRB_valid_out;

  int n_cmp;
  int n_err;

  if_inst_buffer dut (
    .clock            (clock),
    .reset            (reset),
    .if_valid_in      (if_valid_in),
    .if_pc_in         (if_pc_in),
    .mem2proc_data    (mem2proc_data),
    .flush_in         (flush_in),
    .one_ins_en_in    (one_ins_en_in),
    .non_ins_en_in    (non_ins_en_in),
    .if_stall_out     (if_stall_out),
    .if_IRA_out       (if_IRA_out),
    .if_IRB_out       (if_IRB_out),
    .if_NPCA_out      (if_NPCA_out),
    .if_NPCB_out      (if_NPCB_out),
    .if_IRA_valid_out (if_IRA_valid_out),
    .if_IRB_valid_out (if_IRB_valid_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drv(input logic v, input logic [63:0] pc, input logic [63:0] data,
                     input logic fl, input logic one, input logic non);
    if_valid_in   = v;
    if_pc_in      = pc;
    mem2proc_data = data;
    flush_in      = fl;
    one_ins_en_in = one;
    non_ins_en_in = non;
    #1;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_a(input string tag, input logic [31:0] ir, input logic [63:0] npc);
    chk({tag, "_va"}, 64'(if_IRA_valid_out), 64'd1);
    chk({tag, "_ira"}, 64'(if_IRA_out), 64'(ir));
    chk({tag, "_npca"}, if_NPCA_out, npc);
  endtask

  task automatic chk_b(input string tag, input logic [31:0] ir, input logic [63:0] npc);
    chk({tag, "_vb"}, 64'(if_IRB_valid_out), 64'd1);
    chk({tag, "_irb"}, 64'(if_IRB_out), 64'(ir));
    chk({tag, "_npcb"}, if_NPCB_out, npc);
  endtask

  task automatic chk_empty(input string tag);
    chk({tag, "_va"}, 64'(if_IRA_valid_out), 64'd0);
    chk({tag, "_vb"}, 64'(if_IRB_valid_out), 64'd0);
    chk({tag, "_ira"}, 64'(if_IRA_out), 64'(NOOP));
    chk({tag, "_irb"}, 64'(if_IRB_out), 64'(NOOP));
    chk({tag, "_npca"}, if_NPCA_out, 64'd0);
    chk({tag, "_npcb"}, if_NPCB_out, 64'd0);
    chk({tag, "_stall"}, 64'(if_stall_out), 64'd0);
  endtask

  task automatic chk_b_empty(input string tag);
    chk({tag, "_vb"}, 64'(if_IRB_valid_out), 64'd0);
    chk({tag, "_irb"}, 64'(if_IRB_out), 64'(NOOP));
    chk({tag, "_npcb"}, if_NPCB_out, 64'd0);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    drv(1'b0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b1);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    #1 chk_empty("reset");

    // Aligned line at PC 0, consumed two-wide the cycle after it is written.
    drv(1'b1, 64'h0, 64'h0000_0002_0000_0001, 1'b0, 1'b0, 1'b1);
    chk("basic_no_bypass", 64'(if_IRA_valid_out), 64'd0);
    tick();
    drv(1'b0, 64'h0, 64'h0, 1'b0, 1'b0, 1'b0);
    chk_a("basic", 32'h0000_0001, 64'h4);
    chk_b("basic", 32'h0000_0002, 64'h8);
    tick();
    drv(1'b0, 64'h0, 64'h0, 1'b0, 1'b0, 1'b1);
    chk_empty("basic_drained");

    // Fill to DEPTH with decode idle; stall only after the fourth line.
    for (int k = 0; k < 4; k++) begin
      drv(1'b1, 64'(16 + 8 * k), {32'(33 + 2 * k), 32'(32 + 2 * k)}, 1'b0, 1'b0, 1'b1);
      tick();
      chk($sformatf("fill_stall%0d", k), 64'(if_stall_out), (k == 3) ? 64'd1 : 64'd0);
    end
    drv(1'b1, 64'h80, 64'hdead_beef_dead_beef, 1'b0, 1'b0, 1'b1);
    tick();
    chk("fill_stall_held", 64'(if_stall_out), 64'd1);
    for (int k = 0; k < 4; k++) begin
      drv(1'b0, 64'h0, 64'h0, 1'b0, 1'b0, 1'b0);
      chk_a($sformatf("drain%0d", k), 32'(32 + 2 * k), 64'(16 + 8 * k + 4));
      chk_b($sformatf("drain%0d", k), 32'(33 + 2 * k), 64'(16 + 8 * k + 8));
      tick();
    end
    drv(1'b0, 64'h0, 64'h0, 1'b0, 1'b0, 1'b1);
    chk_empty("fill_5th_ignored");

    // Odd PC: only the high word is buffered.
    drv(1'b1, 64'h104, 64'haaaa_0001_bbbb_0000, 1'b0, 1'b0, 1'b1);
    tick();
    drv(1'b0, 64'h0, 64'h0, 1'b0, 1'b0, 1'b1);
    chk_a("odd", 32'haaaa_0001, 64'h108);
    chk_b_empty("odd");

    // Bring count to 3 and drain one per cycle.
    drv(1'b1, 64'h200, 64'h0000_00c2_0000_00c1, 1'b0, 1'b0, 1'b1);
    tick();
    drv(1'b0, 64'h0, 64'h0, 1'b0, 1'b1, 1'b0);
    chk_a("one0", 32'haaaa_0001, 64'h108);
    chk_b("one0", 32'h0000_00c1, 64'h204);
    tick();
    chk_a("one1", 32'h0000_00c1, 64'h204);
    chk_b("one1", 32'h0000_00c2, 64'h208);
    tick();
    chk_a("one2", 32'h0000_00c2, 64'h208);
    chk_b_empty("one2");
    tick();
    drv(1'b0, 64'h0, 64'h0, 1'b0, 1'b0, 1'b1);
    chk_empty("one3");

    // Advance tail to DEPTH-1 (head=tail=5 here), then a two-word write across the wrap.
    drv(1'b1, 64'h300, 64'h0000_00d2_0000_00d1, 1'b0, 1'b0, 1'b1);
    tick();
    drv(1'b0, 64'h0, 64'h0, 1'b0, 1'b0, 1'b0);
    chk_a("pre_wrap", 32'h0000_00d1, 64'h304);
    chk_b("pre_wrap", 32'h0000_00d2, 64'h308);
    tick();
    drv(1'b1, 64'h400, 64'h0000_00e2_0000_00e1, 1'b0, 1'b0, 1'b1);
    tick();
    drv(1'b0, 64'h0, 64'h0, 1'b0, 1'b1, 1'b0);
    chk_a("wrap0", 32'h0000_00e1, 64'h404);
    chk_b("wrap0", 32'h0000_00e2, 64'h408);
    tick();
    chk_a("wrap1", 32'h0000_00e2, 64'h408);
    chk_b_empty("wrap1");
    tick();
    drv(1'b0, 64'h0, 64'h0, 1'b0, 1'b0, 1'b1);
    chk_empty("wrap_drained");

    // Five entries, then flush alongside a new line and a two-wide take.
    drv(1'b1, 64'h500, 64'h0000_00f2_0000_00f1, 1'b0, 1'b0, 1'b1);
    tick();
    drv(1'b1, 64'h508, 64'h0000_00f4_0000_00f3, 1'b0, 1'b0, 1'b1);
    tick();
    drv(1'b1, 64'h514, 64'h0000_00f6_0000_0bad, 1'b0, 1'b0, 1'b1);
    tick();
    drv(1'b1, 64'h600, 64'h1111_1111_2222_2222, 1'b1, 1'b0, 1'b0);
    chk_a("flush_pre", 32'h0000_00f1, 64'h504);
    chk_b("flush_pre", 32'h0000_00f2, 64'h508);
    chk("flush_pre_stall", 64'(if_stall_out), 64'd0);
    tick();
    drv(1'b0, 64'h0, 64'h0, 1'b0, 1'b0, 1'b1);
    chk_empty("flush_post");

    drv(1'b1, 64'h700, 64'h0000_0992_0000_0991, 1'b0, 1'b0, 1'b1);
    tick();
    drv(1'b0, 64'h0, 64'h0, 1'b0, 1'b1, 1'b1);
    chk_a("refill", 32'h0000_0991, 64'h704);
    chk_b("refill", 32'h0000_0992, 64'h708);
    tick();
    // non_ins_en_in must win over one_ins_en_in: nothing consumed.
    chk_a("non_wins", 32'h0000_0991, 64'h704);
    chk_b("non_wins", 32'h0000_0992, 64'h708);

    // Reset mid-operation beats a same-cycle enqueue.
    drv(1'b1, 64'h800, 64'h0000_0772_0000_0771, 1'b0, 1'b0, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    drv(1'b0, 64'h0, 64'h0, 1'b0, 1'b0, 1'b1);
    chk_empty("mid_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
